top_soc: RTL and testbench
==========================

// Module: top_soc
// PURPOSE
//  Top-level SoC shell around a single-port-per-direction word memory of 2**INDEX_WIDTH entries.
//  Independent write and read request channels, each with a registered one-cycle acknowledge.
//  Serves as the bus-facing storage top driven by the SoC bench; all logic on one clock.
// PARAMETERS
//  WORD_WIDTH   4  data word width in bits (default from SoC_pkg)
//  INDEX_WIDTH  4  address width; memory depth = 2**INDEX_WIDTH (default from SoC_pkg)
// PORTS
//  clk_i       in   1            single clock; all state updates on rising edge
//  arstn_i     in   1            reset: synchronous, active-high (1 = reset, sampled at posedge)
//  wr_i        in   1            write request, sampled each posedge
//  ack_wr_o    out  1            write acknowledge, one-cycle pulse
//  wr_data_i   in   WORD_WIDTH   write data
//  wr_index_i  in   INDEX_WIDTH  write address
//  rd_i        in   1            read request, sampled each posedge
//  ack_rd_o    out  1            read acknowledge, one-cycle pulse
//  rd_data_o   out  WORD_WIDTH   read data, valid while ack_rd_o=1
//  rd_index_i  in   INDEX_WIDTH  read address
// BEHAVIOUR
//  - Reset (arstn_i=1 at posedge): all memory words <= 0; ack_wr_o=0, ack_rd_o=0, rd_data_o=0.
//    wr_i/rd_i ignored (may be X) while reset is high; reset mid-operation drops any pending ack.
//  - Write: wr_i=1 at posedge N -> mem[wr_index_i] <= wr_data_i at N; ack_wr_o=1 during N..N+1.
//  - Read: rd_i=1 at posedge N -> rd_data_o <= mem[rd_index_i] at N; ack_rd_o=1 during N..N+1.
//  - Latency: 1 cycle request-to-ack on both channels; no wait states; every request accepted.
//  - Back-to-back requests allowed every cycle; ack stays high for consecutive requests.
//  - No request at posedge -> corresponding ack <= 0; rd_data_o holds its last value.
//  - Simultaneous wr_i and rd_i: both performed same edge. Same index: read returns OLD contents
//    (read-before-write); new data visible to reads from the following edge.
//  - Index covers full depth; no out-of-range case. Data stored/returned unmodified, no width change.
//  - No other state machine; outputs are registers only (no combinational input->output path).
// STRUCTURE
//  - SoC_pkg: WORD_WIDTH=4, INDEX_WIDTH=4 localparams; shared by top and bench.
//  - Sub-module soc_mem: memory array + write port + registered read port + reset clear.
//  - top_soc: instantiates soc_mem, generates ack_wr_o/ack_rd_o registers.
// TESTING
//  1. Reset 1 cycle, then idle -> ack_wr_o=0, ack_rd_o=0, rd_data_o=0.
//  2. Write idx 1 data 4'b0101, next cycle read idx 1 -> ack_wr_o pulse, then ack_rd_o=1, rd_data_o=4'b0101.
//  3. Read idx 2 (never written) -> ack_rd_o=1, rd_data_o=0.
//  4. Overwrite idx 1 with 4'b0111, then read idx 1 -> rd_data_o=4'b0111.
//  5. Same-cycle wr idx 3 = 4'hA and rd idx 3 -> rd_data_o=0 (old); next read idx 3 -> 4'hA.
//  6. Write all 16 indices (data = ~index), assert reset, read all -> every rd_data_o=0.

Source files
------------

// File: rtl/SoC_pkg.sv
// Shared sizing for the SoC storage top and its bench.
package SoC_pkg;

    localparam int WORD_WIDTH  = 4;
    localparam int INDEX_WIDTH = 4;
    localparam int DEPTH       = 2 ** INDEX_WIDTH;

endpackage : SoC_pkg

// File: rtl/soc_mem.sv
// Word memory with one write port and one registered read port.
// A read of the index being written on the same edge returns the old contents.
module soc_mem #(
    parameter int WORD_WIDTH  = SoC_pkg::WORD_WIDTH,
    parameter int INDEX_WIDTH = SoC_pkg::INDEX_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [INDEX_WIDTH-1:0] wr_index_i,
    input  logic [WORD_WIDTH-1:0]  wr_data_i,
    input  logic                   rd_en_i,
    input  logic [INDEX_WIDTH-1:0] rd_index_i,
    output logic [WORD_WIDTH-1:0]  rd_data_o
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [WORD_WIDTH-1:0] rd_data_q;
    logic [WORD_WIDTH-1:0] rd_data_d;

    // rd_data_o holds its value between reads.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_index_i];
        end
    end

    // NOTE: the whole array clears on reset, so it must be flops, not a RAM macro.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_index_i] <= wr_data_i;
        end
    end

    // NOTE: non-blocking updates make the same-edge read see the pre-write word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : soc_mem

// File: rtl/top_soc.sv
// Bus-facing storage top: soc_mem plus registered one-cycle acknowledges
// for the independent write and read channels.
module top_soc #(
    parameter int WORD_WIDTH  = SoC_pkg::WORD_WIDTH,
    parameter int INDEX_WIDTH = SoC_pkg::INDEX_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   wr_i,
    output logic                   ack_wr_o,
    input  logic [WORD_WIDTH-1:0]  wr_data_i,
    input  logic [INDEX_WIDTH-1:0] wr_index_i,
    input  logic                   rd_i,
    output logic                   ack_rd_o,
    output logic [WORD_WIDTH-1:0]  rd_data_o,
    input  logic [INDEX_WIDTH-1:0] rd_index_i
);

    logic ack_wr_q, ack_wr_d;
    logic ack_rd_q, ack_rd_d;

    soc_mem #(
        .WORD_WIDTH (WORD_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_mem (
        .clk_i     (clk_i),
        .rst_i     (arstn_i),
        .wr_en_i   (wr_i),
        .wr_index_i(wr_index_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (rd_i),
        .rd_index_i(rd_index_i),
        .rd_data_o (rd_data_o)
    );

    // Every request is accepted, so the ack is simply the request one edge later.
    always_comb begin
        ack_wr_d = wr_i;
        ack_rd_d = rd_i;
    end

    always_ff @(posedge clk_i) begin
        if (arstn_i) begin
            ack_wr_q <= 1'b0;
            ack_rd_q <= 1'b0;
        end else begin
            ack_wr_q <= ack_wr_d;
            ack_rd_q <= ack_rd_d;
        end
    end

    assign ack_wr_o = ack_wr_q;
    assign ack_rd_o = ack_rd_q;

endmodule : top_soc

// File: tb/tb_top_soc.sv
// Self-checking bench for top_soc: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_top_soc;
    import SoC_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   arstn_i;
    logic                   wr_i;
    logic                   ack_wr_o;
    logic [WORD_WIDTH-1:0]  wr_data_i;
    logic [INDEX_WIDTH-1:0] wr_index_i;
    logic                   rd_i;
    logic                   ack_rd_o;
    logic [WORD_WIDTH-1:0]  rd_data_o;
    logic [INDEX_WIDTH-1:0] rd_index_i;

    int checks = 0;
    int errors = 0;

    top_soc dut (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .wr_i      (wr_i),
        .ack_wr_o  (ack_wr_o),
        .wr_data_i (wr_data_i),
        .wr_index_i(wr_index_i),
        .rd_i      (rd_i),
        .ack_rd_o  (ack_rd_o),
        .rd_data_o (rd_data_o),
        .rd_index_i(rd_index_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: memory as a plain array, acks mirror last-edge requests.
    int  model_mem [DEPTH];
    int  exp_rd_data;
    bit  exp_ack_wr, exp_ack_rd;
    bit  model_valid = 1'b0;

    always @(posedge clk_i) begin
        if (arstn_i === 1'b1) begin
            foreach (model_mem[i]) model_mem[i] = 0;
            exp_rd_data = 0;
            exp_ack_wr  = 0;
            exp_ack_rd  = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            exp_ack_wr = wr_i;
            exp_ack_rd = rd_i;
            if (rd_i) exp_rd_data = model_mem[rd_index_i];
            if (wr_i) model_mem[wr_index_i] = int'(wr_data_i);
        end
    end

    always @(negedge clk_i) begin
        if (model_valid) begin
            check("ack_wr", {31'd0, ack_wr_o}, {31'd0, exp_ack_wr});
            check("ack_rd", {31'd0, ack_rd_o}, {31'd0, exp_ack_rd});
            check("rd_data", {28'd0, rd_data_o}, exp_rd_data);
        end
    end

    // Apply one cycle of stimulus; returns at the negedge after the sampling edge.
    task automatic drive(input bit rst, input bit wr, input int wi, input int wd,
                         input bit rd, input int ri);
        arstn_i    = rst;
        wr_i       = wr;
        wr_index_i = INDEX_WIDTH'(wi);
        wr_data_i  = WORD_WIDTH'(wd);
        rd_i       = rd;
        rd_index_i = INDEX_WIDTH'(ri);
        @(negedge clk_i);
    endtask

    initial begin
        // 1. reset then idle
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("idle_ack_wr", {31'd0, ack_wr_o}, 32'd0);
        check("idle_ack_rd", {31'd0, ack_rd_o}, 32'd0);
        check("idle_rd_data", {28'd0, rd_data_o}, 32'd0);

        // 2. write idx1 = 0101, read back
        drive(0, 1, 1, 4'b0101, 0, 0);
        check("wr1_ack", {31'd0, ack_wr_o}, 32'd1);
        drive(0, 0, 0, 0, 1, 1);
        check("rd1_ack_wr_drop", {31'd0, ack_wr_o}, 32'd0);
        check("rd1_ack", {31'd0, ack_rd_o}, 32'd1);
        check("rd1_data", {28'd0, rd_data_o}, 32'h5);

        // 3. unwritten idx2 reads zero
        drive(0, 0, 0, 0, 1, 2);
        check("rd2_data", {28'd0, rd_data_o}, 32'h0);

        // idle: ack drops, data holds
        drive(0, 0, 0, 0, 0, 0);
        check("idle_ack_rd_drop", {31'd0, ack_rd_o}, 32'd0);

        // 4. overwrite idx1, back-to-back read
        drive(0, 1, 1, 4'b0111, 0, 0);
        drive(0, 0, 0, 0, 1, 1);
        check("rd1_new_data", {28'd0, rd_data_o}, 32'h7);

        // 5. same-cycle write/read of idx3 -> old data, then new
        drive(0, 1, 3, 4'hA, 1, 3);
        check("rbw_old", {28'd0, rd_data_o}, 32'h0);
        check("rbw_both_ack", {30'd0, ack_wr_o, ack_rd_o}, 32'd3);
        drive(0, 0, 0, 0, 1, 3);
        check("rbw_new", {28'd0, rd_data_o}, 32'hA);

        // 6. fill all, reset (requests asserted but ignored), read all -> zero
        for (int i = 0; i < DEPTH; i++) drive(0, 1, i, ~i, 0, 0);
        drive(0, 0, 0, 0, 1, 6);
        check("fill_rd6", {28'd0, rd_data_o}, 32'h9);
        drive(1, 1, 5, 4'hF, 1, 5);
        check("rst_ack_wr", {31'd0, ack_wr_o}, 32'd0);
        check("rst_ack_rd", {31'd0, ack_rd_o}, 32'd0);
        check("rst_rd_data", {28'd0, rd_data_o}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 1, i);
            check($sformatf("cleared_%0d", i), {28'd0, rd_data_o}, 32'd0);
        end

        // Randomized traffic; narrow index range sometimes to force collisions.
        for (int n = 0; n < 600; n++) begin
            int span;
            span = ($urandom_range(0, 3) == 0) ? 2 : DEPTH;
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 1), $urandom_range(0, span - 1), $urandom_range(0, 15),
                  $urandom_range(0, 1), $urandom_range(0, span - 1));
        end
        drive(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_top_soc
